// File: rtl/div_share_arbiter_pkg.sv
// Shared types and constants for the dual-lane divider arbiter.
// Optional feature macro used in this slice: DIV_EARLY_OUT_EN.
package div_share_arbiter_pkg;

  localparam int ES_TO_DIV_BUS_MD = 67;
  localparam int DIV_TO_ES_BUS_MD = 33;
  localparam int DIV_ITERS        = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_FIX  = 2'b10
  } div_state_e;

  typedef struct packed {
    logic        valid;
    logic        use_mod;
    logic        is_unsigned;
    logic [31:0] src1;
    logic [31:0] src2;
  } div_req_t;

  function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
    return (is_signed && value[31]) ? -value : value;
  endfunction

endpackage

// File: rtl/div_share_arbiter_div_core.sv
// Iterative 32-step restoring divider with sign fix-up, owned by div_share_arbiter.
// DIV_EARLY_OUT_EN: skip the iterations when the quotient is trivially zero or the divisor is zero.
module div_core
  import div_share_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        kill,
  input  logic        start,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        use_mod,
  input  logic        is_unsigned,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  div_state_e  state;
  logic [5:0]  step;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] divisor;
  logic        neg_q;
  logic        neg_r;
  logic        mod_sel;
  logic        div_zero;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign mag_a     = magnitude(src1, !is_unsigned);
  assign mag_b     = magnitude(src2, !is_unsigned);
  assign rem_shift = {rem, quo[31]};
  assign diff      = rem_shift - {1'b0, divisor};

  // Divide-by-zero forces the all-ones quotient; the remainder falls out of the datapath as src1.
  assign q_fix  = div_zero ? '1 : (neg_q ? -quo : quo);
  assign r_fix  = neg_r ? -rem : rem;
  assign result = mod_sel ? r_fix : q_fix;
  assign busy   = (state != DIV_IDLE);
  assign done   = (state == DIV_FIX);

  always_ff @(posedge clk) begin
    if (reset || kill) begin
      state    <= DIV_IDLE;
      step     <= '0;
      quo      <= '0;
      rem      <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      mod_sel  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            quo      <= mag_a;
            rem      <= '0;
            divisor  <= mag_b;
            step     <= '0;
            neg_q    <= !is_unsigned && (src1[31] ^ src2[31]);
            neg_r    <= !is_unsigned && src1[31];
            mod_sel  <= use_mod;
            div_zero <= (src2 == '0);
`ifdef DIV_EARLY_OUT_EN
            if ((src2 == '0) || (mag_b > mag_a)) begin
              quo   <= '0;
              rem   <= mag_a;
              state <= DIV_FIX;
            end else begin
              state <= DIV_BUSY;
            end
`else
            state <= DIV_BUSY;
`endif
          end
        end
        DIV_BUSY: begin
          if (!diff[32]) begin
            rem <= diff[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= rem_shift[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          step <= step + 6'd1;
          if (step == 6'(DIV_ITERS - 1)) state <= DIV_FIX;
        end
        DIV_FIX:  state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one iterative divider between two EXM lanes; lane 0 (older) has fixed priority.
// DIV_EARLY_OUT_EN is honoured inside div_core.
module div_share_arbiter
  import div_share_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ES_TO_DIV_BUS_MD-1:0] es_to_div_bus0,
  input  logic [ES_TO_DIV_BUS_MD-1:0] es_to_div_bus1,
  output logic [XLEN:0]               div_to_es_bus0,
  output logic [XLEN:0]               div_to_es_bus1,
  input  logic                        pair_adv,
  input  logic                        flush_ES,
  output logic                        div_busy
);

  div_req_t    req0;
  div_req_t    req1;
  div_req_t    sel;
  logic        done0;
  logic        done1;
  logic [31:0] res0;
  logic [31:0] res1;
  logic        active_lane;
  logic        grant_lane;
  logic        start;
  logic        core_busy;
  logic        core_done;
  logic [31:0] core_result;

  assign req0 = div_req_t'(es_to_div_bus0);
  assign req1 = div_req_t'(es_to_div_bus1);
  assign sel  = grant_lane ? req1 : req0;

  // A lane that already holds a result is skipped until pair_adv clears it.
  always_comb begin
    start      = 1'b0;
    grant_lane = 1'b0;
    if (!core_busy) begin
      if (req0.valid && !done0) begin
        start = 1'b1;
      end else if (req1.valid && !done1) begin
        start      = 1'b1;
        grant_lane = 1'b1;
      end
    end
  end

  div_core u_div_core (
    .clk         (clk),
    .reset       (reset),
    .kill        (flush_ES),
    .start       (start),
    .src1        (sel.src1),
    .src2        (sel.src2),
    .use_mod     (sel.use_mod),
    .is_unsigned (sel.is_unsigned),
    .busy        (core_busy),
    .done        (core_done),
    .result      (core_result)
  );

  always_ff @(posedge clk) begin
    if (reset || flush_ES) begin
      done0       <= 1'b0;
      done1       <= 1'b0;
      res0        <= '0;
      res1        <= '0;
      active_lane <= 1'b0;
    end else begin
      if (pair_adv) begin
        done0 <= 1'b0;
        done1 <= 1'b0;
      end
      if (core_done) begin
        if (active_lane) begin
          res1  <= core_result;
          done1 <= 1'b1;
        end else begin
          res0  <= core_result;
          done0 <= 1'b1;
        end
      end
      if (start) active_lane <= grant_lane;
    end
  end

  assign div_to_es_bus0 = {res0, done0};
  assign div_to_es_bus1 = {res1, done1};
  assign div_busy       = core_busy;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Scoreboard bench for div_share_arbiter: stimulus pushes expected results, a monitor pops on ok.
module tb_div_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pair_adv;
  logic        flush_ES;
  logic [66:0] bus0;
  logic [66:0] bus1;
  logic [32:0] out0;
  logic [32:0] out1;
  logic        div_busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] result;
    int          cycle;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  localparam int LAT = 34;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_EARLY = 2;
`else
  localparam int LAT_EARLY = 34;
`endif

  div_share_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .es_to_div_bus0 (bus0),
    .es_to_div_bus1 (bus1),
    .div_to_es_bus0 (out0),
    .div_to_es_bus1 (out1),
    .pair_adv       (pair_adv),
    .flush_ES       (flush_ES),
    .div_busy       (div_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic popCheck(input int lane, input logic [31:0] res);
    exp_t e;
    tests++;
    if ((lane == 0 && q0.size() == 0) || (lane == 1 && q1.size() == 0)) begin
      fails++;
      $display("[TB] FAIL lane%0d unexpected ok: result %0h at cycle %0d, nothing expected", lane, res, cyc);
    end else begin
      e = (lane == 0) ? q0.pop_front() : q1.pop_front();
      if (res !== e.result || cyc != e.cycle) begin
        fails++;
        $display("[TB] FAIL lane%0d result: got %0h at cycle %0d, expected %0h at cycle %0d",
                 lane, res, cyc, e.result, e.cycle);
      end
    end
  endtask

  logic ok0_prev = 1'b0;
  logic ok1_prev = 1'b0;

  always @(negedge clk) begin
    if (out0[0] && !ok0_prev) popCheck(0, out0[32:1]);
    if (out1[0] && !ok1_prev) popCheck(1, out1[32:1]);
    ok0_prev <= out0[0];
    ok1_prev <= out1[0];
  end

  task automatic waitUntil(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int lane, input bit use_mod, input bit is_uns,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expected, input int lat, input bit expect_it);
    logic [66:0] req;
    exp_t e;
    req = {1'b1, use_mod, is_uns, a, b};
    if (lane == 0) bus0 = req;
    else           bus1 = req;
    if (expect_it) begin
      e.result = expected;
      e.cycle  = cyc + lat;
      if (lane == 0) q0.push_back(e);
      else           q1.push_back(e);
    end
  endtask

  task automatic advancePair();
    pair_adv = 1'b1;
    bus0     = '0;
    bus1     = '0;
    waitUntil(cyc + 1);
    pair_adv = 1'b0;
  endtask

  task automatic runOne(input int lane, input bit use_mod, input bit is_uns,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expected, input int lat, input string name);
    int t;
    t = cyc;
    applyStimulus(lane, use_mod, is_uns, a, b, expected, lat, 1'b1);
    waitUntil(t + lat + 1);
    advancePair();
    @(negedge clk);
    checkOutput({name, " ok cleared"}, (lane == 0) ? out0[0] : out1[0], 0);
    waitUntil(cyc + 1);
  endtask

  initial begin
    int t;
    reset    = 1'b1;
    pair_adv = 1'b0;
    flush_ES = 1'b0;
    bus0     = '0;
    bus1     = '0;
    waitUntil(3);
    @(negedge clk);
    checkOutput("reset bus0", out0, 0);
    checkOutput("reset bus1", out1, 0);
    checkOutput("reset busy", div_busy, 0);
    waitUntil(cyc + 1);
    reset = 1'b0;
    waitUntil(cyc + 1);

    // Lane 0 signed 7 / -2 with busy window edges.
    t = cyc;
    applyStimulus(0, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT, 1'b1);
    waitUntil(t + 1);
    @(negedge clk);
    checkOutput("busy at t+1", div_busy, 1);
    waitUntil(t + 33);
    @(negedge clk);
    checkOutput("busy at t+33", div_busy, 1);
    waitUntil(t + 34);
    @(negedge clk);
    checkOutput("busy low at t+34", div_busy, 0);
    waitUntil(t + 35);
    advancePair();
    @(negedge clk);
    checkOutput("ok0 cleared t+36", out0[0], 0);
    waitUntil(cyc + 1);

    // Both lanes at once: lane 0 quotient first, lane 1 remainder 34 cycles later.
    t = cyc;
    applyStimulus(0, 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, LAT, 1'b1);
    applyStimulus(1, 1'b1, 1'b1, 32'd100, 32'd7, 32'd2, 2 * LAT, 1'b1);
    waitUntil(t + 2 * LAT + 1);
    advancePair();
    @(negedge clk);
    checkOutput("pair ok0 cleared", out0[0], 0);
    checkOutput("pair ok1 cleared", out1[0], 0);
    waitUntil(cyc + 1);

    runOne(1, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT, "overflow");
    runOne(1, 1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_EARLY, "div0 quot");
    runOne(1, 1'b1, 1'b0, 32'd5, 32'd0, 32'd5, LAT_EARLY, "div0 rem");
    runOne(0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT, "neg rem");
    runOne(0, 1'b0, 1'b1, 32'd3, 32'd9, 32'd0, LAT_EARLY, "small quot");
    runOne(0, 1'b1, 1'b1, 32'd3, 32'd9, 32'd3, LAT_EARLY, "small rem");

    // Flush a busy division, then start a fresh one the very next cycle.
    t = cyc;
    applyStimulus(0, 1'b0, 1'b1, 32'd1000, 32'd3, 32'd0, LAT, 1'b0);
    waitUntil(t + 10);
    flush_ES = 1'b1;
    waitUntil(t + 11);
    flush_ES = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, LAT, 1'b1);
    @(negedge clk);
    checkOutput("flush busy", div_busy, 0);
    checkOutput("flush bus0", out0, 0);
    checkOutput("flush bus1", out1, 0);
    waitUntil(t + 46);
    advancePair();
    @(negedge clk);
    checkOutput("post-flush ok0 cleared", out0[0], 0);
    waitUntil(cyc + 1);

    // Reset with pair_adv and flush while lane 0 holds a result and lane 1 is busy.
    t = cyc;
    applyStimulus(0, 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, LAT, 1'b1);
    applyStimulus(1, 1'b0, 1'b1, 32'd1000, 32'd3, 32'd0, LAT, 1'b0);
    waitUntil(t + 40);
    reset    = 1'b1;
    pair_adv = 1'b1;
    flush_ES = 1'b1;
    bus0     = '0;
    bus1     = '0;
    waitUntil(t + 41);
    reset    = 1'b0;
    pair_adv = 1'b0;
    flush_ES = 1'b0;
    @(negedge clk);
    checkOutput("reset mid bus0", out0, 0);
    checkOutput("reset mid bus1", out1, 0);
    checkOutput("reset mid busy", div_busy, 0);
    waitUntil(t + 80);

    checkOutput("lane0 queue drained", q0.size(), 0);
    checkOutput("lane1 queue drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
